// File: rtl/branch_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : branch_ctrl
//  Description : ID-stage branch/jump sequencer around the compare unit.
//                Decodes br_type into the compare code, stalls ID until the
//                operands are available, and makes the taken/not-taken
//                decision combinationally in the same cycle. A taken
//                branch/jump redirects the PC and squashes the wrong-path
//                IF/ID instruction for one cycle (no delay slot). It also
//                keeps saturating branch statistics.
//
//  Ports       : clock, reset           - rising-edge clock, sync active-high reset
//                id_valid, br_type      - ID instruction and its branch class
//                rs_ready, rt_ready     - operand availability
//                kill                   - squash of the ID instruction
//                is_branch              - compare-unit result
//                br_target, rs_val      - redirect candidates
//                cmp_code               - compare-unit opcode
//                stall, flush           - pipeline hold / IF-ID squash
//                pc_sel, pc_next        - PC redirect
//                link_we                - $ra write strobe for jal
//                wait_err               - sticky operand-wait overrun flag
//                br_count, taken_count  - saturating statistics
//
//  Revision    : 1.0 - initial release
// ============================================================================
module branch_ctrl #(
    parameter int CNT_W    = 16,
    parameter int MAX_WAIT = 8,
    parameter int WAIT_W   = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             id_valid,
    input  logic [2:0]       br_type,
    input  logic             rs_ready,
    input  logic             rt_ready,
    input  logic             kill,
    input  logic             is_branch,
    input  logic [31:0]      br_target,
    input  logic [31:0]      rs_val,
    output logic [1:0]       cmp_code,
    output logic             stall,
    output logic             flush,
    output logic             pc_sel,
    output logic [31:0]      pc_next,
    output logic             link_we,
    output logic             wait_err,
    output logic [CNT_W-1:0] br_count,
    output logic [CNT_W-1:0] taken_count
);

    // State encoding
    localparam logic [1:0] c_ST_IDLE  = 2'd0;
    localparam logic [1:0] c_ST_WAIT  = 2'd1;
    localparam logic [1:0] c_ST_FLUSH = 2'd2;

    // Branch type encoding
    localparam logic [2:0] c_BR_BEQ = 3'b001;
    localparam logic [2:0] c_BR_BNE = 3'b010;
    localparam logic [2:0] c_BR_J   = 3'b011;
    localparam logic [2:0] c_BR_JAL = 3'b100;
    localparam logic [2:0] c_BR_JR  = 3'b101;

    localparam logic [WAIT_W-1:0] c_WAIT_MAX = WAIT_W'(MAX_WAIT);
    localparam logic [WAIT_W-1:0] c_WAIT_ONE = {{(WAIT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0]  c_CNT_MAX  = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0]  c_CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [1:0]        r_state;
    logic [1:0]        w_state_nxt;
    logic [WAIT_W-1:0] r_wait_cnt;
    logic [WAIT_W-1:0] w_wait_nxt;
    logic              r_wait_err;
    logic [CNT_W-1:0]  r_br_count;
    logic [CNT_W-1:0]  r_taken_count;

    logic              w_type_ok;
    logic              w_present;
    logic              w_ops_ready;
    logic              w_stall;
    logic              w_decide;
    logic              w_taken;
    logic [1:0]        w_cmp_code;

    assign w_type_ok = (br_type >= c_BR_BEQ) && (br_type <= c_BR_JR);

    // FLUSH ignores the ID instruction entirely; kill and reset suppress it.
    assign w_present = ~reset & id_valid & w_type_ok & ~kill &
                       (r_state != c_ST_FLUSH);

    always_comb begin
        w_ops_ready = 1'b1;
        case (br_type)
            c_BR_BEQ, c_BR_BNE: w_ops_ready = rs_ready & rt_ready;
            c_BR_JR:            w_ops_ready = rs_ready;
            default:            w_ops_ready = 1'b1;
        endcase
    end

    always_comb begin
        w_cmp_code = 2'b00;
        if (w_present) begin
            case (br_type)
                c_BR_BEQ:                   w_cmp_code = 2'b01;
                c_BR_BNE:                   w_cmp_code = 2'b10;
                c_BR_J, c_BR_JAL, c_BR_JR:  w_cmp_code = 2'b11;
                default:                    w_cmp_code = 2'b00;
            endcase
        end
    end

    assign w_stall  = w_present & ~w_ops_ready;
    assign w_decide = w_present & w_ops_ready;
    assign w_taken  = w_decide & is_branch;

    // Only a stalled branch keeps WAIT_OPS; decisions, kills, non-branches
    // and the FLUSH cycle all fall back to IDLE unless a redirect happened.
    always_comb begin
        w_state_nxt = c_ST_IDLE;
        if (r_state != c_ST_FLUSH) begin
            if (w_stall) begin
                w_state_nxt = c_ST_WAIT;
            end else if (w_taken) begin
                w_state_nxt = c_ST_FLUSH;
            end
        end
    end

    // Wait counter runs only across consecutive stall cycles and saturates
    // at MAX_WAIT; anything else clears it.
    always_comb begin
        w_wait_nxt = '0;
        if (w_stall) begin
            if (r_wait_cnt != c_WAIT_MAX) begin
                w_wait_nxt = r_wait_cnt + c_WAIT_ONE;
            end else begin
                w_wait_nxt = r_wait_cnt;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state       <= c_ST_IDLE;
            r_wait_cnt    <= '0;
            r_wait_err    <= 1'b0;
            r_br_count    <= '0;
            r_taken_count <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_wait_cnt <= w_wait_nxt;
            if (w_stall && (w_wait_nxt == c_WAIT_MAX)) begin
                r_wait_err <= 1'b1;
            end
            if (w_decide && (r_br_count != c_CNT_MAX)) begin
                r_br_count <= r_br_count + c_CNT_ONE;
            end
            if (w_taken && (r_taken_count != c_CNT_MAX)) begin
                r_taken_count <= r_taken_count + c_CNT_ONE;
            end
        end
    end

    assign cmp_code    = w_cmp_code;
    assign stall       = w_stall;
    assign flush       = (r_state == c_ST_FLUSH);
    assign pc_sel      = w_taken;
    assign pc_next     = w_taken ? ((br_type == c_BR_JR) ? rs_val : br_target)
                                 : 32'h0;
    assign link_we     = w_decide & (br_type == c_BR_JAL);
    assign wait_err    = r_wait_err;
    assign br_count    = r_br_count;
    assign taken_count = r_taken_count;

endmodule
`default_nettype wire

// File: tb/tb_branch_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_branch_ctrl
//  Description : Directed self-checking bench for branch_ctrl (CNT_W = 4 so
//                counter saturation is reachable quickly).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_branch_ctrl;

    localparam int c_CNT_W = 4;

    logic               clock;
    logic               reset;
    logic               id_valid;
    logic [2:0]         br_type;
    logic               rs_ready;
    logic               rt_ready;
    logic               kill;
    logic               is_branch;
    logic [31:0]        br_target;
    logic [31:0]        rs_val;
    logic [1:0]         cmp_code;
    logic               stall;
    logic               flush;
    logic               pc_sel;
    logic [31:0]        pc_next;
    logic               link_we;
    logic               wait_err;
    logic [c_CNT_W-1:0] br_count;
    logic [c_CNT_W-1:0] taken_count;

    int r_checks;
    int r_fails;

    branch_ctrl #(
        .CNT_W    (c_CNT_W),
        .MAX_WAIT (8),
        .WAIT_W   (4)
    ) u_dut (
        .clock       (clock),
        .reset       (reset),
        .id_valid    (id_valid),
        .br_type     (br_type),
        .rs_ready    (rs_ready),
        .rt_ready    (rt_ready),
        .kill        (kill),
        .is_branch   (is_branch),
        .br_target   (br_target),
        .rs_val      (rs_val),
        .cmp_code    (cmp_code),
        .stall       (stall),
        .flush       (flush),
        .pc_sel      (pc_sel),
        .pc_next     (pc_next),
        .link_we     (link_we),
        .wait_err    (wait_err),
        .br_count    (br_count),
        .taken_count (taken_count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        r_checks++;
        if (obs !== exp) begin
            r_fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Advance to 1 ns after the next rising edge (input drive point).
    task automatic cyc();
        @(posedge clock);
        #1;
    endtask

    // Wait from the drive point to the falling edge (sample point).
    task automatic settle();
        #4;
    endtask

    task automatic idle_in();
        id_valid  = 1'b0;
        br_type   = 3'b000;
        rs_ready  = 1'b1;
        rt_ready  = 1'b1;
        kill      = 1'b0;
        is_branch = 1'b0;
        br_target = 32'h0;
        rs_val    = 32'h0;
    endtask

    task automatic set_br(input logic [2:0] t, input logic rs, input logic rt,
                          input logic isb, input logic [31:0] tgt, input logic [31:0] rsv);
        id_valid  = 1'b1;
        br_type   = t;
        rs_ready  = rs;
        rt_ready  = rt;
        kill      = 1'b0;
        is_branch = isb;
        br_target = tgt;
        rs_val    = rsv;
    endtask

    initial begin
        r_checks = 0;
        r_fails  = 0;
        idle_in();
        reset = 1'b1;
        cyc();
        cyc();

        // Outputs forced low while reset is high, even with a ready beq.
        set_br(3'b001, 1'b1, 1'b1, 1'b1, 32'h40, 32'h0);
        settle();
        check("rst_cmp",    32'(cmp_code), 32'd0);
        check("rst_pcsel",  32'(pc_sel),   32'd0);
        check("rst_stall",  32'(stall),    32'd0);
        cyc();
        reset = 1'b0;
        idle_in();
        settle();
        check("rst_flush",  32'(flush),       32'd0);
        check("rst_brcnt",  32'(br_count),    32'd0);
        check("rst_tkcnt",  32'(taken_count), 32'd0);
        check("rst_werr",   32'(wait_err),    32'd0);
        cyc();

        // beq ready and taken.
        set_br(3'b001, 1'b1, 1'b1, 1'b1, 32'h0000_0040, 32'h0);
        settle();
        check("beq_cmp",    32'(cmp_code), 32'd1);
        check("beq_pcsel",  32'(pc_sel),   32'd1);
        check("beq_pcnext", pc_next,       32'h40);
        check("beq_stall",  32'(stall),    32'd0);
        check("beq_link",   32'(link_we),  32'd0);
        cyc();
        idle_in();
        settle();
        check("beq_flush",  32'(flush),       32'd1);
        check("beq_brcnt",  32'(br_count),    32'd1);
        check("beq_tkcnt",  32'(taken_count), 32'd1);
        cyc();
        settle();
        check("beq_flush_end", 32'(flush), 32'd0);
        cyc();

        // bne ready, not taken.
        set_br(3'b010, 1'b1, 1'b1, 1'b0, 32'h0000_0080, 32'h0);
        settle();
        check("bne_cmp",    32'(cmp_code), 32'd2);
        check("bne_pcsel",  32'(pc_sel),   32'd0);
        check("bne_pcnext", pc_next,       32'h0);
        cyc();
        idle_in();
        settle();
        check("bne_flush",  32'(flush),       32'd0);
        check("bne_brcnt",  32'(br_count),    32'd2);
        check("bne_tkcnt",  32'(taken_count), 32'd1);
        cyc();

        // beq waiting 3 cycles on rt.
        for (int i = 0; i < 3; i++) begin
            set_br(3'b001, 1'b1, 1'b0, 1'b1, 32'h0000_0080, 32'h0);
            settle();
            check("wait3_stall", 32'(stall),    32'd1);
            check("wait3_cmp",   32'(cmp_code), 32'd1);
            check("wait3_pcsel", 32'(pc_sel),   32'd0);
            cyc();
        end
        set_br(3'b001, 1'b1, 1'b1, 1'b1, 32'h0000_0080, 32'h0);
        settle();
        check("wait3_dec_stall", 32'(stall),  32'd0);
        check("wait3_dec_pcsel", 32'(pc_sel), 32'd1);
        check("wait3_dec_pc",    pc_next,     32'h80);
        cyc();
        idle_in();
        settle();
        check("wait3_flush", 32'(flush),       32'd1);
        check("wait3_werr",  32'(wait_err),    32'd0);
        check("wait3_brcnt", 32'(br_count),    32'd3);
        check("wait3_tkcnt", 32'(taken_count), 32'd2);
        cyc();

        // jr waiting 10 cycles on rs; wait_err visible after the 8th stall cycle.
        for (int i = 0; i < 10; i++) begin
            set_br(3'b101, 1'b0, 1'b0, 1'b1, 32'h0000_DEAD, 32'h0000_1000);
            settle();
            check("jr_stall", 32'(stall),    32'd1);
            check("jr_cmp",   32'(cmp_code), 32'd3);
            check("jr_werr",  32'(wait_err), (i >= 8) ? 32'd1 : 32'd0);
            cyc();
        end
        set_br(3'b101, 1'b1, 1'b0, 1'b1, 32'h0000_DEAD, 32'h0000_1000);
        settle();
        check("jr_dec_stall", 32'(stall),  32'd0);
        check("jr_dec_pcsel", 32'(pc_sel), 32'd1);
        check("jr_dec_pc",    pc_next,     32'h1000);
        cyc();
        idle_in();
        settle();
        check("jr_flush", 32'(flush),       32'd1);
        check("jr_werr_sticky", 32'(wait_err), 32'd1);
        check("jr_brcnt", 32'(br_count),    32'd4);
        check("jr_tkcnt", 32'(taken_count), 32'd3);
        cyc();

        // jal taken; the same jal stays in ID during FLUSH and is ignored.
        set_br(3'b100, 1'b0, 1'b0, 1'b1, 32'h0000_0200, 32'h0);
        settle();
        check("jal_link",  32'(link_we),  32'd1);
        check("jal_cmp",   32'(cmp_code), 32'd3);
        check("jal_pcsel", 32'(pc_sel),   32'd1);
        check("jal_pc",    pc_next,       32'h200);
        cyc();
        settle();
        check("jal_fl_flush", 32'(flush),    32'd1);
        check("jal_fl_link",  32'(link_we),  32'd0);
        check("jal_fl_pcsel", 32'(pc_sel),   32'd0);
        check("jal_fl_cmp",   32'(cmp_code), 32'd0);
        cyc();
        idle_in();
        settle();
        check("jal_brcnt", 32'(br_count),    32'd5);
        check("jal_tkcnt", 32'(taken_count), 32'd4);
        check("jal_flush_end", 32'(flush),   32'd0);
        cyc();

        // kill in WAIT_OPS.
        set_br(3'b001, 1'b1, 1'b0, 1'b1, 32'h0000_0300, 32'h0);
        settle();
        check("kill_pre_stall", 32'(stall), 32'd1);
        cyc();
        kill = 1'b1;
        settle();
        check("kill_stall", 32'(stall),  32'd0);
        check("kill_pcsel", 32'(pc_sel), 32'd0);
        check("kill_cmp",   32'(cmp_code), 32'd0);
        cyc();
        idle_in();
        settle();
        check("kill_flush", 32'(flush),       32'd0);
        check("kill_brcnt", 32'(br_count),    32'd5);
        check("kill_tkcnt", 32'(taken_count), 32'd4);
        cyc();

        // kill during FLUSH has no effect on the flush pulse.
        set_br(3'b011, 1'b0, 1'b0, 1'b1, 32'h0000_0400, 32'h0);
        settle();
        check("j_pcsel", 32'(pc_sel), 32'd1);
        cyc();
        idle_in();
        kill = 1'b1;
        settle();
        check("killfl_flush", 32'(flush), 32'd1);
        cyc();
        kill = 1'b0;
        settle();
        check("killfl_brcnt", 32'(br_count),    32'd6);
        check("killfl_tkcnt", 32'(taken_count), 32'd5);
        cyc();

        // 17 more taken jumps: both 4-bit counters saturate at 0xF.
        for (int i = 0; i < 17; i++) begin
            set_br(3'b011, 1'b0, 1'b0, 1'b1, 32'h0000_0500, 32'h0);
            cyc();
            idle_in();
            cyc();
        end
        settle();
        check("sat_brcnt", 32'(br_count),    32'hF);
        check("sat_tkcnt", 32'(taken_count), 32'hF);
        cyc();

        // Reset asserted during FLUSH.
        set_br(3'b001, 1'b1, 1'b1, 1'b1, 32'h0000_0600, 32'h0);
        cyc();
        idle_in();
        reset = 1'b1;
        settle();
        check("rstfl_flush_pre", 32'(flush), 32'd1);
        cyc();
        reset = 1'b0;
        settle();
        check("rstfl_flush", 32'(flush),       32'd0);
        check("rstfl_brcnt", 32'(br_count),    32'd0);
        check("rstfl_tkcnt", 32'(taken_count), 32'd0);
        check("rstfl_werr",  32'(wait_err),    32'd0);
        check("rstfl_pcsel", 32'(pc_sel),      32'd0);
        cyc();

        $display("End of test - %0d assertions evaluated, %0d failures", r_checks, r_fails);
        $finish;
    end

endmodule
`default_nettype wire
